clk_div_trig_gen: RTL and testbench
===================================

Name: clk_div_trig_gen

Overview:
- Parametrised successor to the fixed divide-by-15 strobe counter.
- Divides the system clock by a runtime-programmable ratio and produces a divided clock-enable output, either a single-cycle pulse or ~50% square wave.
- Also produces NUM_TRIG independent one-cycle trigger strobes at programmable count positions.
- Feeds Costas loop sample/update timing and downstream trigger logic.

Parameters:
CNT_W, 6, width of the phase counter and all count-valued ports
DEFAULT_DIV, 15, divide ratio loaded at reset (must satisfy 2 <= DEFAULT_DIV <= 2^CNT_W-1)
NUM_TRIG, 2, number of independent trigger channels (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  count enable; counter holds when low
div_val  in  CNT_W  requested divide ratio
div_load  in  1  one-cycle strobe: capture div_val into shadow register
mode  in  1  0 = pulse output, 1 = square output
trig_pos  in  NUM_TRIG*CNT_W  per-channel trigger count position, channel i at bits [i*CNT_W +: CNT_W]
clk_div  out  1  divided clock-enable / square output
trig  out  NUM_TRIG  per-channel one-cycle trigger strobes
wrap  out  1  one-cycle strobe while count==0 following a wrap
count  out  CNT_W  current phase counter value

Behaviour:
- Reset (async, reset_n low):
  - count=0, div_active=DEFAULT_DIV, div_shadow=DEFAULT_DIV, shadow_pending=0.
  - clk_div=0, trig=0, wrap=0.
  - All state is released on the first rising edge after reset_n goes high. Reset asserted mid-period aborts the period immediately.
- Counter, on each edge with enable=1:
  - If count==div_active-1: count <- 0. If shadow_pending, div_active <- div_shadow and shadow_pending <- 0.
  - Otherwise count <- count+1.
  - The period is exactly div_active clocks: count runs 0..div_active-1.
- div_load:
  - On div_load, div_shadow <- max(div_val,2) and shadow_pending <- 1. Values 0 and 1 are clamped to 2.
  - The new ratio takes effect only at the next wrap. Periods are never truncated or glitched.
  - div_load coincident with a wrap edge: the old shadow (if pending) is applied at that wrap, and the new value is pended for the following wrap.
  - div_load is honoured regardless of enable.
- Registered outputs reflect the count value being loaded on the same edge (next-count), so each output is aligned with the count it describes:
  - wrap=1 exactly during cycles where count==0 reached by wrap. It does not assert for count==0 immediately after reset.
  - mode=0: clk_div=1 exactly when wrap=1.
  - mode=1: clk_div=1 while count < ceil(div_active/2), else 0. After reset, clk_div stays 0 until the first wrap.
  - trig[i]=1 for the single cycle where count==trig_pos[i], for the first and every subsequent period. A channel with trig_pos[i] >= div_active never fires. Multiple channels may fire in the same cycle.
- enable=0:
  - count, div_active and clk_div hold.
  - trig and wrap are forced 0.
  - On resume, counting continues from the held count. No strobe is repeated for a count already strobed.
- mode and trig_pos changes are sampled every cycle and take effect at the next edge.

Optional Feature:
- Macro: CLK_DIV_PHASE_SYNC_EN
- Defined:
  - Adds input port sync_in (1 bit).
  - sync_in=1 with enable=1 forces count <- 0 on that edge and applies any pending shadow ratio.
  - wrap, mode-0 clk_div, and trig channels with trig_pos==0 assert in the following cycle, exactly as for a natural wrap.
  - sync_in takes priority over the normal increment. It is ignored while enable=0.
- Not defined: no sync_in port; counter phase is determined only by reset and the divide ratio.

Test Plan:
- Reset then enable=1, defaults (div 15, mode 0), trig_pos={13,12} -> clk_div/wrap pulse every 15 clocks, first on clock 15 after release; trig[0] at count 12, trig[1] at count 13, each one cycle wide.
- mode=1, DEFAULT_DIV=15 -> clk_div high 8 cycles, low 7 cycles, repeating. div_load with div_val=10 -> high 5 / low 5, starting at the next wrap.
- div_load with div_val=4 issued at count 7, then div_val=6 on the wrap edge -> current period completes at 15, next period is 4, then 6 thereafter. div_val=1 -> period 2.
- trig_pos[0]=20 with div 15 -> trig[0] never asserts. trig_pos both =3 -> both trig bits high in the same cycle.
- enable low for 5 cycles at count 9 -> count held at 9, trig/wrap 0. Next wrap occurs 5 cycles later than nominal. Async reset at count 11 -> all outputs 0 immediately and count 0.
- With CLK_DIV_PHASE_SYNC_EN, sync_in at count 6 -> count=0 next cycle, wrap and clk_div (mode 0) pulse. The next wrap follows div_active clocks later.

Source files
------------

// File: rtl/clk_div_trig_gen.sv
// Programmable clock divider: pulse or square clock-enable, wrap strobe and NUM_TRIG trigger strobes.
// Define CLK_DIV_PHASE_SYNC_EN to add the sync_in phase-restart input.
module clk_div_trig_gen #(
    parameter int CNT_W       = 6,
    parameter int DEFAULT_DIV = 15,
    parameter int NUM_TRIG    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [CNT_W-1:0]          div_val,
    input  logic                      div_load,
    input  logic                      mode,
    input  logic [NUM_TRIG*CNT_W-1:0] trig_pos,
`ifdef CLK_DIV_PHASE_SYNC_EN
    input  logic                      sync_in,
`endif
    output logic                      clk_div,
    output logic [NUM_TRIG-1:0]       trig,
    output logic                      wrap,
    output logic [CNT_W-1:0]          count
);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    div_active_q, div_active_d;
    logic [CNT_W-1:0]    div_shadow_q, div_shadow_d;
    logic                pending_q, pending_d;
    logic                started_q, started_d;
    logic                clk_div_q, clk_div_d;
    logic                wrap_q, wrap_d;
    logic [NUM_TRIG-1:0] trig_q, trig_d;
    logic                sync_w;
    logic                restart;
    logic [CNT_W:0]      half_w;

`ifdef CLK_DIV_PHASE_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    // Outputs are computed from the next count so they line up with the count they describe.
    always_comb begin
        restart      = (count_q == div_active_q - 1'b1) || sync_w;
        count_d      = count_q;
        div_active_d = div_active_q;
        div_shadow_d = div_shadow_q;
        pending_d    = pending_q;
        started_d    = started_q;
        clk_div_d    = clk_div_q;
        wrap_d       = 1'b0;
        trig_d       = '0;
        half_w       = '0;
        if (enable) begin
            if (restart) begin
                count_d   = '0;
                started_d = 1'b1;
                if (pending_q) begin
                    div_active_d = div_shadow_q;
                    pending_d    = 1'b0;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
            wrap_d = restart;
            for (int i = 0; i < NUM_TRIG; i++)
                trig_d[i] = (count_d == trig_pos[i*CNT_W +: CNT_W]);
            half_w    = ({1'b0, div_active_d} + 1'b1) >> 1;
            clk_div_d = mode ? (started_d && ({1'b0, count_d} < half_w)) : restart;
        end
        // A load on the wrap edge pends behind the shadow being applied on that same edge.
        if (div_load) begin
            div_shadow_d = (div_val < MIN_DIV) ? MIN_DIV : div_val;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q      <= '0;
            div_active_q <= DEF_DIV;
            div_shadow_q <= DEF_DIV;
            pending_q    <= 1'b0;
            started_q    <= 1'b0;
            clk_div_q    <= 1'b0;
            wrap_q       <= 1'b0;
            trig_q       <= '0;
        end else begin
            count_q      <= count_d;
            div_active_q <= div_active_d;
            div_shadow_q <= div_shadow_d;
            pending_q    <= pending_d;
            started_q    <= started_d;
            clk_div_q    <= clk_div_d;
            wrap_q       <= wrap_d;
            trig_q       <= trig_d;
        end
    end

    assign count   = count_q;
    assign clk_div = clk_div_q;
    assign wrap    = wrap_q;
    assign trig    = trig_q;
endmodule

// File: tb/tb_clk_div_trig_gen.sv
// Bench for clk_div_trig_gen: directed scenarios with literal expectations, then random stimulus
// checked every cycle against an integer model of the divider.
module tb_clk_div_trig_gen;
    localparam int CNT_W    = 6;
    localparam int NUM_TRIG = 2;
    localparam int DEF      = 15;

    logic                      clock = 1'b0;
    logic                      reset_n = 1'b0;
    logic                      enable = 1'b0;
    logic                      div_load = 1'b0;
    logic                      mode = 1'b0;
    logic [CNT_W-1:0]          div_val = '0;
    logic [NUM_TRIG*CNT_W-1:0] trig_pos = '0;
`ifdef CLK_DIV_PHASE_SYNC_EN
    logic                      sync_in = 1'b0;
`endif
    logic                      clk_div, wrap;
    logic [NUM_TRIG-1:0]       trig;
    logic [CNT_W-1:0]          count;

    int vec = 0, errs = 0;
    bit chk_en = 0;

    int m_cnt, m_div, m_shadow;
    bit m_pend, m_started, m_clk, m_wrap;
    bit [NUM_TRIG-1:0] m_trig;

    clk_div_trig_gen #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF), .NUM_TRIG(NUM_TRIG)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .div_val(div_val),
        .div_load(div_load), .mode(mode), .trig_pos(trig_pos),
`ifdef CLK_DIV_PHASE_SYNC_EN
        .sync_in(sync_in),
`endif
        .clk_div(clk_div), .trig(trig), .wrap(wrap), .count(count)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    // Reference: a period is m_div clocks; a new ratio lands only when a period ends.
    initial forever begin
        bit w, sy;
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            m_cnt = 0; m_div = DEF; m_shadow = DEF; m_pend = 0; m_started = 0;
            m_clk = 0; m_wrap = 0; m_trig = '0;
        end else begin
            sy = 0;
`ifdef CLK_DIV_PHASE_SYNC_EN
            sy = sync_in;
`endif
            w = 0;
            m_wrap = 0;
            m_trig = '0;
            if (enable) begin
                if (sy || m_cnt == m_div - 1) begin
                    w = 1;
                    m_cnt = 0;
                    m_started = 1;
                    if (m_pend) begin m_div = m_shadow; m_pend = 0; end
                end else begin
                    m_cnt = m_cnt + 1;
                end
                m_wrap = w;
                for (int i = 0; i < NUM_TRIG; i++)
                    m_trig[i] = (m_cnt == int'(trig_pos[i*CNT_W +: CNT_W]));
                m_clk = mode ? (m_started && m_cnt < (m_div + 1) / 2) : w;
            end
            if (div_load) begin
                m_shadow = (int'(div_val) < 2) ? 2 : int'(div_val);
                m_pend = 1;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            vec++;
            if (count !== CNT_W'(m_cnt) || clk_div !== m_clk || wrap !== m_wrap || trig !== m_trig) begin
                errs++;
                $display("FAIL cycle_cmp t=%0t: dut count=%0d clk_div=%b wrap=%b trig=%b, model count=%0d clk_div=%b wrap=%b trig=%b",
                         $time, count, clk_div, wrap, trig, m_cnt, m_clk, m_wrap, m_trig);
            end
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        vec++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        vec++;
        errs++;
        $display("FAIL %s: event not seen within 200 cycles", name);
    endtask

    task automatic wait_count(input int v);
        int n = 0;
        while (count != CNT_W'(v) && n < 200) begin @(negedge clock); n++; end
        if (n >= 200) timeout("wait_count");
    endtask

    // Cycles until the next wrap strobe (advances at least one cycle).
    task automatic period(output int n);
        n = 0;
        do begin @(negedge clock); n++; end while (!wrap && n < 200);
        if (n >= 200) timeout("period");
    endtask

    task automatic wait_wrap();
        int n;
        period(n);
    endtask

    task automatic count_high(input int cycles, output int h);
        h = 0;
        repeat (cycles) begin
            h += int'(clk_div);
            @(negedge clock);
        end
    endtask

    task automatic load(input int v);
        div_val = CNT_W'(v);
        div_load = 1'b1;
        @(negedge clock);
        div_load = 1'b0;
    endtask

    initial begin
        int n, h, acc;
        trig_pos = {6'd13, 6'd12};
        repeat (2) @(negedge clock);
        chk_en = 1;
        lit("reset_count", int'(count), 0);
        lit("reset_outs", int'({clk_div, wrap, trig}), 0);

        enable = 1'b1;
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        lit("trig0_at_12", int'(trig), 1);
        @(negedge clock);
        lit("trig1_at_13", int'(trig), 2);
        @(negedge clock);
        lit("no_wrap_at_14", int'(wrap), 0);
        @(negedge clock);
        lit("first_wrap_clk15", int'({wrap, clk_div}), 3);
        period(n);
        lit("period_15", n, 15);

        mode = 1'b1;
        wait_wrap();
        count_high(15, h);
        lit("square15_high", h, 8);
        lit("square15_wrap", int'(wrap), 1);
        load(10);
        wait_wrap();
        count_high(10, h);
        lit("square10_high", h, 5);
        lit("square10_wrap", int'(wrap), 1);

        mode = 1'b0;
        load(15);
        wait_wrap();
        wait_wrap();
        wait_count(7);
        load(4);
        wait_count(14);
        div_val = 6'd6;
        div_load = 1'b1;
        @(negedge clock);
        div_load = 1'b0;
        lit("load_on_wrap_edge", int'(wrap), 1);
        period(n); lit("period_4", n, 4);
        period(n); lit("period_6a", n, 6);
        period(n); lit("period_6b", n, 6);
        load(1);
        wait_wrap();
        period(n); lit("period_clamp2a", n, 2);
        period(n); lit("period_clamp2b", n, 2);

        load(15);
        wait_wrap();
        wait_wrap();
        trig_pos = {6'd3, 6'd20};
        acc = 0;
        repeat (30) begin @(negedge clock); acc |= int'(trig[0]); end
        lit("trig0_out_of_range", acc, 0);
        trig_pos = {6'd3, 6'd3};
        wait_count(3);
        lit("trig_both_same", int'(trig), 3);

        trig_pos = {6'd13, 6'd12};
        wait_wrap();
        wait_count(9);
        enable = 1'b0;
        repeat (5) begin
            @(negedge clock);
            lit("hold_count", int'(count), 9);
            lit("hold_strobes", int'({wrap, trig}), 0);
        end
        enable = 1'b1;
        period(n);
        lit("resume_to_wrap", n, 6);

        trig_pos = {6'd11, 6'd12};
        wait_count(11);
        lit("trig1_before_reset", int'(trig), 2);
        #2 reset_n = 1'b0;
        #1;
        lit("async_count", int'(count), 0);
        lit("async_outs", int'({clk_div, wrap, trig}), 0);
        @(negedge clock);
        reset_n = 1'b1;

`ifdef CLK_DIV_PHASE_SYNC_EN
        wait_count(6);
        sync_in = 1'b1;
        @(negedge clock);
        sync_in = 1'b0;
        lit("sync_count", int'(count), 0);
        lit("sync_strobe", int'({wrap, clk_div}), 3);
        period(n);
        lit("sync_period", n, 15);
`endif

        repeat (3000) begin
            @(negedge clock);
            reset_n  = ($urandom % 800) != 0;
            enable   = ($urandom % 10) != 0;
            div_load = ($urandom % 20) == 0;
            div_val  = (($urandom % 8) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 24));
            if (($urandom % 50) == 0) mode = ~mode;
            if (($urandom % 50) == 0)
                for (int i = 0; i < NUM_TRIG; i++) trig_pos[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 24));
`ifdef CLK_DIV_PHASE_SYNC_EN
            sync_in = ($urandom % 40) == 0;
`endif
        end
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
